// File: rtl/mdio_phy_slave.sv
// rtl/mdio_phy_slave.sv - Clause 22 MDIO PHY-side responder serving a 32 x 16-bit register file
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN (accept a frame after a single preamble one)
module mdio_phy_slave #(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [15:0] PHY_ID1     = 16'h0141,
    parameter logic [15:0] PHY_ID2     = 16'h0CC2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_we,
    output logic [15:0] host_rdata,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
    logic                   mdc_s, mdio_s, mdc_prev, bit_event;
    logic [3:0]             bit_cnt;
    logic [5:0]             pre_cnt;
    logic                   pre_ok, field_last, op_read, match;
    logic [15:0]            shift_in, shift_out;
    logic [4:0]             regad;
    logic [15:0]            regs [32];
    logic                   mdio_commit, host_commit;
    logic [15:0]            commit_data;

    function automatic logic is_id_reg(input logic [4:0] a);
        return a[4:1] == 4'b0001;
    endfunction

    function automatic logic [15:0] reg_value(input logic [4:0] a);
        if (a == 5'd2)      return PHY_ID1;
        else if (a == 5'd3) return PHY_ID2;
        else                return regs[a];
    endfunction

    assign mdc_s     = mdc_sync[SYNC_STAGES-1];
    assign mdio_s    = mdio_sync[SYNC_STAGES-1];
    assign bit_event = mdc_s & ~mdc_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_prev  <= mdc_s;
        end
    end

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign pre_ok = (pre_cnt != 6'd0);
`else
    assign pre_ok = pre_cnt[5];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        field_last = 1'b0;
        case (state)
            S_OP, S_TA:       field_last = (bit_cnt == 4'd1);
            S_PHYAD, S_REGAD: field_last = (bit_cnt == 4'd4);
            S_DATA:           field_last = (bit_cnt == 4'd15);
            default:          field_last = 1'b0;
        endcase
        if (bit_event) begin
            case (state)
                S_IDLE:  if (!mdio_s && pre_ok) state_n = S_START;
                S_START: state_n = mdio_s ? S_OP : S_IDLE;
                S_OP:    if (field_last) state_n = (shift_in[0] ^ mdio_s) ? S_PHYAD : S_IDLE;
                S_PHYAD: if (field_last) state_n = S_REGAD;
                S_REGAD: if (field_last) state_n = S_TA;
                S_TA:    if (field_last) state_n = S_DATA;
                S_DATA:  if (field_last) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Frame datapath: field shifter, preamble counter and read-data serializer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 4'd0;
            pre_cnt   <= 6'd0;
            shift_in  <= 16'd0;
            shift_out <= 16'd0;
            op_read   <= 1'b0;
            match     <= 1'b0;
            regad     <= 5'd0;
            mdio_oe   <= 1'b0;
            mdio_o    <= 1'b0;
        end else if (bit_event) begin
            shift_in <= {shift_in[14:0], mdio_s};
            bit_cnt  <= (state_n != state) ? 4'd0 : bit_cnt + 4'd1;
            if (state != S_IDLE || !mdio_s) pre_cnt <= 6'd0;
            else if (pre_cnt != 6'h3F)      pre_cnt <= pre_cnt + 6'd1;
            if (state == S_OP && field_last)    op_read <= shift_in[0] & ~mdio_s;
            if (state == S_PHYAD && field_last) match <= ({shift_in[3:0], mdio_s} == PHY_ADDR);
            if (state == S_REGAD && field_last) regad <= {shift_in[3:0], mdio_s};
            if (state == S_DATA && field_last) begin
                mdio_oe <= 1'b0;
                mdio_o  <= 1'b0;
            end else if (state == S_TA && bit_cnt == 4'd0 && match && op_read) begin
                mdio_oe   <= 1'b1;
                mdio_o    <= 1'b0;
                shift_out <= reg_value(regad);
            end else if (mdio_oe) begin
                mdio_o    <= shift_out[15];
                shift_out <= {shift_out[14:0], 1'b0};
            end
        end
    end

    assign mdio_commit = bit_event && state == S_DATA && field_last && match && !op_read;
    assign commit_data = {shift_in[14:0], mdio_s};
    // MDIO wins a same-cycle collision on one register
    assign host_commit = host_we && !is_id_reg(host_addr) && !(mdio_commit && host_addr == regad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 16'd0;
            host_rdata <= 16'd0;
        end else begin
            wr_strobe <= mdio_commit;
            if (mdio_commit) begin
                wr_addr <= regad;
                wr_data <= commit_data;
                if (!is_id_reg(regad)) regs[regad] <= commit_data;
            end
            if (host_commit) regs[host_addr] <= host_wdata;
            host_rdata <= reg_value(host_addr);
        end
    end
endmodule

// File: tb/tb_mdio_phy_slave.sv
// tb/tb_mdio_phy_slave.sv - self-checking bench for mdio_phy_slave (table vectors, random frames, corner sequences)
module tb_mdio_phy_slave;
    localparam int H    = 6;
    localparam int SYNC = 2;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int PRE_MIN = 1;
`else
    localparam int PRE_MIN = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_o, mdio_oe, wr_strobe;
    logic [4:0]  host_addr = 5'd0;
    logic [4:0]  wr_addr;
    logic [15:0] host_wdata = 16'd0;
    logic [15:0] host_rdata, wr_data;
    logic        host_we = 1'b0;
    logic        m_oe = 1'b1;
    logic        m_val = 1'b1;
    logic        pad;

    assign pad = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

    mdio_phy_slave dut (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(pad), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int oe_cycles = 0;
    int strobe_cnt = 0;
    logic [4:0]  coll_addr = 5'd0;
    logic [15:0] coll_data = 16'd0;
    logic [15:0] model [32];

    always @(posedge clk) begin
        if (mdio_oe)   oe_cycles++;
        if (wr_strobe) strobe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_val(input logic [4:0] a);
        if (a == 5'd2)      return 16'h0141;
        else if (a == 5'd3) return 16'h0CC2;
        else                return model[a];
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [15:0] d);
        if (a != 5'd2 && a != 5'd3) model[a] = d;
    endfunction

    // One MDC period as driven by the master; cap is the pad value just before the rising edge.
    // act: 0 plain, 1 host write in the commit cycle, 2 assert reset mid-bit.
    task automatic mbit(input logic b, input logic drv, input int act, output logic cap);
        m_oe  = drv;
        m_val = b;
        repeat (H) @(posedge clk);
        #1 cap = pad;
        mdc = 1'b1;
        if (act == 1) begin
            repeat (SYNC) @(posedge clk);
            #1 host_addr = coll_addr;
            host_wdata = coll_data;
            host_we = 1'b1;
            @(posedge clk);
            #1 host_we = 1'b0;
            repeat (H - SYNC - 1) @(posedge clk);
        end else if (act == 2) begin
            repeat (SYNC + 2) @(posedge clk);
            #1 check("oe_before_rst", mdio_oe, 1'b1);
            rst_n = 1'b0;
            #1 check("oe_async_release", mdio_oe, 1'b0);
            repeat (H - SYNC - 2) @(posedge clk);
        end else begin
            repeat (H) @(posedge clk);
        end
        #1 mdc = 1'b0;
    endtask

    task automatic frame(input int pre, input logic rd, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] wd, input int last_act,
                         output logic [15:0] rdat, output logic ta_bit, output int oe_d, output int st_d);
        logic [13:0] hdr;
        logic cap;
        int oe0, st0;
        oe0 = oe_cycles;
        st0 = strobe_cnt;
        rdat = 16'd0;
        ta_bit = 1'b1;
        hdr = {2'b01, (rd ? 2'b10 : 2'b01), phy, ra};
        for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1, 0, cap);
        for (int i = 13; i >= 0; i--) mbit(hdr[i], 1'b1, 0, cap);
        if (rd) begin
            mbit(1'b1, 1'b0, 0, cap);
            mbit(1'b1, 1'b0, 0, ta_bit);
            for (int i = 15; i >= 0; i--) begin
                mbit(1'b1, 1'b0, 0, cap);
                rdat[i] = cap;
            end
        end else begin
            mbit(1'b1, 1'b1, 0, cap);
            mbit(1'b0, 1'b1, 0, cap);
            for (int i = 15; i >= 0; i--) mbit(wd[i], 1'b1, (i == 0) ? last_act : 0, cap);
        end
        m_oe = 1'b1;
        m_val = 1'b1;
        repeat (4) @(posedge clk);
        #1 oe_d = oe_cycles - oe0;
        st_d = strobe_cnt - st0;
    endtask

    task automatic host_read(input logic [4:0] a, output logic [15:0] d);
        host_addr = a;
        @(posedge clk);
        #1 d = host_rdata;
    endtask

    // Runs one frame and checks it against the reference model; acc is the model's verdict.
    task automatic run_checked(input string tag, input int pre, input logic rd, input logic [4:0] phy,
                               input logic [4:0] ra, input logic [15:0] wd, input logic acc,
                               input logic [15:0] exp);
        logic [15:0] rdat, hd;
        logic ta_bit;
        int oe_d, st_d;
        frame(pre, rd, phy, ra, wd, 0, rdat, ta_bit, oe_d, st_d);
        check({tag, "_oe_end"}, mdio_oe, 1'b0);
        if (rd) begin
            check({tag, "_oe_seen"}, oe_d > 0, acc);
            check({tag, "_strobe"}, st_d, 0);
            if (acc) begin
                check({tag, "_ta_bit"}, ta_bit, 1'b0);
                check({tag, "_rdata"}, rdat, exp);
            end
        end else begin
            check({tag, "_oe_seen"}, oe_d, 0);
            check({tag, "_strobe"}, st_d, acc ? 1 : 0);
            if (acc) begin
                check({tag, "_wr_addr"}, wr_addr, ra);
                check({tag, "_wr_data"}, wr_data, wd);
                model_write(ra, wd);
            end
            host_read(ra, hd);
            check({tag, "_host_rd"}, hd, exp);
        end
    endtask

    typedef struct {
        int          pre;
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic        acc;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [15:0] rdat, hd;
        logic ta_bit, cap, acc, rd, prev_full;
        logic [13:0] hdr;
        logic [4:0] phy, ra;
        logic [15:0] wd;
        int oe_d, st_d, pre;
        logic acc20;
        logic [15:0] exp5;

        for (int i = 0; i < 32; i++) model[i] = 16'd0;
        acc20 = (PRE_MIN <= 20);
        exp5  = acc20 ? 16'h1234 : 16'h0000;
        vt[0]  = '{32, 1'b0, 5'd1, 5'd4,  16'hBEEF, 1'b1,  16'hBEEF};
        vt[1]  = '{32, 1'b1, 5'd1, 5'd2,  16'h0000, 1'b1,  16'h0141};
        vt[2]  = '{32, 1'b1, 5'd7, 5'd2,  16'h0000, 1'b0,  16'h0000};
        vt[3]  = '{32, 1'b1, 5'd1, 5'd3,  16'h0000, 1'b1,  16'h0CC2};
        vt[4]  = '{20, 1'b0, 5'd1, 5'd5,  16'h1234, acc20, exp5};
        vt[5]  = '{32, 1'b1, 5'd1, 5'd5,  16'h0000, 1'b1,  exp5};
        vt[6]  = '{32, 1'b0, 5'd1, 5'd2,  16'hFFFF, 1'b1,  16'h0141};
        vt[7]  = '{32, 1'b1, 5'd1, 5'd2,  16'h0000, 1'b1,  16'h0141};
        vt[8]  = '{40, 1'b0, 5'd1, 5'd31, 16'hA5A5, 1'b1,  16'hA5A5};
        vt[9]  = '{32, 1'b1, 5'd1, 5'd4,  16'h0000, 1'b1,  16'hBEEF};
        vt[10] = '{33, 1'b0, 5'd9, 5'd4,  16'h0000, 1'b0,  16'hBEEF};

        repeat (3) @(posedge clk);
        #1 check("rst_oe", mdio_oe, 1'b0);
        check("rst_o", mdio_o, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 5'd0);
        check("rst_wr_data", wr_data, 16'd0);
        check("rst_host_rdata", host_rdata, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++)
            run_checked($sformatf("vec%0d", v), vt[v].pre, vt[v].rd, vt[v].phy, vt[v].ra,
                        vt[v].wd, vt[v].acc, vt[v].exp);

        // Same-register collision: MDIO data must win over the host write
        coll_addr = 5'd6;
        coll_data = 16'h1111;
        frame(32, 1'b0, 5'd1, 5'd6, 16'h2222, 1, rdat, ta_bit, oe_d, st_d);
        model_write(5'd6, 16'h2222);
        check("coll_same_strobe", st_d, 1);
        host_read(5'd6, hd);
        check("coll_same_reg6", hd, 16'h2222);

        // Different-register collision: both writes land
        coll_addr = 5'd8;
        coll_data = 16'h3333;
        frame(32, 1'b0, 5'd1, 5'd7, 16'h4444, 1, rdat, ta_bit, oe_d, st_d);
        model_write(5'd7, 16'h4444);
        model_write(5'd8, 16'h3333);
        host_read(5'd7, hd);
        check("coll_diff_reg7", hd, 16'h4444);
        host_read(5'd8, hd);
        check("coll_diff_reg8", hd, 16'h3333);

        // Random frames; a short preamble only follows a fully tracked frame
        prev_full = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rd  = $urandom_range(0, 1);
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
            ra  = 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            pre = (prev_full && $urandom_range(0, 3) == 0) ? $urandom_range(8, 31) : $urandom_range(32, 36);
            prev_full = (pre >= 32);
            acc = (phy == 5'd1) && (pre >= PRE_MIN);
            if (rd) run_checked($sformatf("rnd%0d", n), pre, rd, phy, ra, wd, acc, model_val(ra));
            else    run_checked($sformatf("rnd%0d", n), pre, rd, phy, ra, wd, acc,
                                (acc && ra != 5'd2 && ra != 5'd3) ? wd : model_val(ra));
        end

        for (int a = 0; a < 32; a++) begin
            host_read(5'(a), hd);
            check($sformatf("sweep_reg%0d", a), hd, model_val(5'(a)));
        end

        // Reset during the 8th data bit of a read of register 2
        for (int i = 0; i < 32; i++) mbit(1'b1, 1'b1, 0, cap);
        hdr = {2'b01, 2'b10, 5'd1, 5'd2};
        for (int i = 13; i >= 0; i--) mbit(hdr[i], 1'b1, 0, cap);
        mbit(1'b1, 1'b0, 0, cap);
        mbit(1'b1, 1'b0, 0, cap);
        for (int i = 0; i < 7; i++) mbit(1'b1, 1'b0, 0, cap);
        mbit(1'b1, 1'b0, 2, cap);
        m_oe = 1'b1;
        m_val = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("oe_after_rst", mdio_oe, 1'b0);
        for (int i = 0; i < 32; i++) model[i] = 16'd0;
        run_checked("post_rst_rd2", 32, 1'b1, 5'd1, 5'd2, 16'd0, 1'b1, 16'h0141);
        host_read(5'd4, hd);
        check("post_rst_reg4", hd, model_val(5'd4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
